// File: rtl/avalon_multi_timer.sv
// ============================================================================
// avalon_multi_timer
//
// NUM_CH independent down-counting interval timers behind one Avalon-MM slave
// with a 32-bit data path. Each channel has its own 8-bit prescaler, period,
// snapshot and (optionally) PWM compare register. Each channel raises its own
// IRQ line, and a combined IRQ is the OR of all the channel lines.
//
// Parameters
//   NUM_CH          number of channels, 1..8
//   COUNTER_W       counter / period width, 8..32
//   DEFAULT_PERIOD  reset value of every PERIOD register and counter
//                   (truncated to COUNTER_W)
//   ADDR_W          derived word-address width: 3 + clog2(NUM_CH)
//
// Ports
//   clk         in   1        system clock
//   reset_n     in   1        asynchronous, active-low reset
//   chipselect  in   1        slave select
//   address     in   ADDR_W   word address {channel, reg[2:0]}
//   write_n     in   1        active-low single-cycle write strobe
//   writedata   in   32       write data
//   readdata    out  32       registered read data (1-cycle latency)
//   irq_vec     out  NUM_CH   per-channel IRQ = TO & ITO
//   irq         out  1        OR of irq_vec
//   pwm_out     out  NUM_CH   PWM outputs
//
// Register map (per channel, reg = address[2:0])
//   0 STATUS   r {RUN, TO}; any write clears TO
//   1 CONTROL  r {CONT, ITO}; w bit0 ITO, bit1 CONT, bit2 START, bit3 STOP
//   2 PERIOD   r/w; a write force-reloads the counter and stops the channel
//   3 SNAP     any write captures the live counter; read returns the capture
//   4 PRESC    r/w [7:0]; the counter ticks every PRESC+1 clocks
//   5 COMPARE  r/w PWM threshold (only with MTIMER_PWM_EN)
//   6,7        reserved, read 0
//
// Configuration macro
//   MTIMER_PWM_EN  defined: COMPARE register and registered PWM outputs,
//                  pwm_out[ch] = RUN & (count < COMPARE).
//                  undefined: no COMPARE register, reg 5 reads 0,
//                  pwm_out tied to 0.
// ============================================================================
module avalon_multi_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          COUNTER_W      = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h249EF,
    localparam int         ADDR_W         = 3 + $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              chipselect,
    input  logic [ADDR_W-1:0] address,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] irq_vec,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_SNAP    = 3'd3;
    localparam logic [2:0] REG_PRESC   = 3'd4;
    localparam logic [2:0] REG_COMPARE = 3'd5;

    localparam logic [COUNTER_W-1:0] RESET_COUNT = DEFAULT_PERIOD[COUNTER_W-1:0];

    logic [ADDR_W-1:0]    ch_field;
    logic [2:0]           reg_sel;
    logic                 bus_write;

    logic [NUM_CH-1:0]    ch_hit;
    logic [NUM_CH-1:0]    wr_status;
    logic [NUM_CH-1:0]    wr_control;
    logic [NUM_CH-1:0]    wr_period;
    logic [NUM_CH-1:0]    wr_snap;
    logic [NUM_CH-1:0]    wr_presc;
    logic [NUM_CH-1:0]    start_req;
    logic [NUM_CH-1:0]    stop_req;
    logic [NUM_CH-1:0]    tick;
    logic [NUM_CH-1:0]    expire;

    logic [COUNTER_W-1:0] count  [NUM_CH];
    logic [COUNTER_W-1:0] period [NUM_CH];
    logic [COUNTER_W-1:0] snap   [NUM_CH];
    logic [7:0]           presc  [NUM_CH];
    logic [7:0]           pcnt   [NUM_CH];
    logic [NUM_CH-1:0]    run;
    logic [NUM_CH-1:0]    to_flag;
    logic [NUM_CH-1:0]    ito;
    logic [NUM_CH-1:0]    cont;

    logic [31:0]          read_mux;

    // The channel index is everything above the 3-bit register field. Shifting
    // rather than slicing keeps this legal when NUM_CH = 1 (no channel bits).
    assign ch_field  = address >> 3;
    assign reg_sel   = address[2:0];
    assign bus_write = chipselect && !write_n;

    // Per-channel write decode plus the prescaler tick / expiry events.
    // A channel only ticks while RUN; expiry is a tick seen with the counter
    // already at zero.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ch_hit[c]     = bus_write && (ch_field == ADDR_W'(c));
            wr_status[c]  = ch_hit[c] && (reg_sel == REG_STATUS);
            wr_control[c] = ch_hit[c] && (reg_sel == REG_CONTROL);
            wr_period[c]  = ch_hit[c] && (reg_sel == REG_PERIOD);
            wr_snap[c]    = ch_hit[c] && (reg_sel == REG_SNAP);
            wr_presc[c]   = ch_hit[c] && (reg_sel == REG_PRESC);
            start_req[c]  = wr_control[c] && writedata[2];
            stop_req[c]   = wr_control[c] && writedata[3];
            tick[c]       = run[c] && (pcnt[c] == 8'd0);
            expire[c]     = tick[c] && (count[c] == '0);
        end
    end

    // Channel state. Priorities worth remembering:
    //  - a PERIOD write reloads counter and prescaler, overriding any tick;
    //  - START beats STOP, the PERIOD-write stop and the one-shot stop;
    //  - a TO set beats a STATUS-write clear so no expiry is ever lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                count[c]   <= RESET_COUNT;
                period[c]  <= RESET_COUNT;
                snap[c]    <= '0;
                presc[c]   <= 8'd0;
                pcnt[c]    <= 8'd0;
                run[c]     <= 1'b0;
                to_flag[c] <= 1'b0;
                ito[c]     <= 1'b0;
                cont[c]    <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_period[c]) begin
                    period[c] <= writedata[COUNTER_W-1:0];
                    count[c]  <= writedata[COUNTER_W-1:0];
                    pcnt[c]   <= presc[c];
                end else if (run[c]) begin
                    if (tick[c]) begin
                        pcnt[c]  <= presc[c];
                        count[c] <= expire[c] ? period[c] : count[c] - 1'b1;
                    end else begin
                        pcnt[c] <= pcnt[c] - 8'd1;
                    end
                end

                if (start_req[c]) begin
                    run[c] <= 1'b1;
                end else if (stop_req[c] || wr_period[c] || (expire[c] && !cont[c])) begin
                    run[c] <= 1'b0;
                end

                if (expire[c]) begin
                    to_flag[c] <= 1'b1;
                end else if (wr_status[c]) begin
                    to_flag[c] <= 1'b0;
                end

                if (wr_control[c]) begin
                    ito[c]  <= writedata[0];
                    cont[c] <= writedata[1];
                end

                if (wr_presc[c]) begin
                    presc[c] <= writedata[7:0];
                end

                // SNAP takes the value the counter holds in the write cycle,
                // before any decrement happening on the same edge.
                if (wr_snap[c]) begin
                    snap[c] <= count[c];
                end
            end
        end
    end

`ifdef MTIMER_PWM_EN
    logic [COUNTER_W-1:0] compare [NUM_CH];
    logic [NUM_CH-1:0]    wr_compare;
    logic [NUM_CH-1:0]    pwm_q;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_compare[c] = ch_hit[c] && (reg_sel == REG_COMPARE);
        end
    end

    // PWM is high while running and below the threshold; registered so the
    // pins are glitch-free, which makes them lag the counter by one clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                compare[c] <= '0;
            end
            pwm_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_compare[c]) begin
                    compare[c] <= writedata[COUNTER_W-1:0];
                end
                pwm_q[c] <= run[c] && (count[c] < compare[c]);
            end
        end
    end

    assign pwm_out = pwm_q;
`else
    assign pwm_out = '0;
`endif

    // Read mux: decoded from the address every cycle, chipselect not needed.
    // Channel indices beyond NUM_CH match no channel and so read 0.
    always_comb begin
        read_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_field == ADDR_W'(c)) begin
                case (reg_sel)
                    REG_STATUS:  read_mux = {30'b0, run[c], to_flag[c]};
                    REG_CONTROL: read_mux = {30'b0, cont[c], ito[c]};
                    REG_PERIOD:  read_mux = 32'(period[c]);
                    REG_SNAP:    read_mux = 32'(snap[c]);
                    REG_PRESC:   read_mux = {24'b0, presc[c]};
`ifdef MTIMER_PWM_EN
                    REG_COMPARE: read_mux = 32'(compare[c]);
`endif
                    default:     read_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= read_mux;
        end
    end

    assign irq_vec = to_flag & ito;
    assign irq     = |irq_vec;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// ============================================================================
// tb_avalon_multi_timer
//
// Self-checking bench for avalon_multi_timer (NUM_CH=4, COUNTER_W=32).
// A behavioural model describes every channel by the number of running clocks
// elapsed since its last reload; the live count, expiry instant and PWM level
// follow from that with plain arithmetic. A compare process checks readdata,
// irq_vec, irq and pwm_out against the model on every falling edge, and the
// directed sequence adds hand-computed literal expectations.
// Honours MTIMER_PWM_EN the same way the design does.
// ============================================================================
module tb_avalon_multi_timer;

    localparam int NUM_CH    = 4;
    localparam int COUNTER_W = 32;
    localparam int ADDR_W    = 5;
    localparam longint DEF_PERIOD = 64'h249EF;

    logic              clk;
    logic              reset_n;
    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [NUM_CH-1:0] irq_vec;
    logic              irq;
    logic [NUM_CH-1:0] pwm_out;

    int tests;
    int fails;
    bit check_en;

    avalon_multi_timer #(
        .NUM_CH    (NUM_CH),
        .COUNTER_W (COUNTER_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (chipselect),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_vec    (irq_vec),
        .irq        (irq),
        .pwm_out    (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    longint      m_period  [NUM_CH];
    longint      m_snap    [NUM_CH];
    longint      m_compare [NUM_CH];
    longint      m_elapsed [NUM_CH];
    longint      m_presc   [NUM_CH];
    bit          m_run     [NUM_CH];
    bit          m_to      [NUM_CH];
    bit          m_ito     [NUM_CH];
    bit          m_cont    [NUM_CH];
    logic [31:0] exp_rd;
    logic [NUM_CH-1:0] exp_pwm;

    bit     m_wr, m_hit, m_exp, m_start, m_stop, m_pw;
    int     m_ch, m_rg;
    longint m_cnt;

    // Live count = period minus the number of whole prescaled ticks elapsed.
    function automatic longint modelCount(input int c);
        return m_period[c] - m_elapsed[c] / (m_presc[c] + 1);
    endfunction

    function automatic logic [31:0] modelRead(input int ch, input int rg);
        if (ch >= NUM_CH) return 32'd0;
        case (rg)
            0: return {30'd0, m_run[ch], m_to[ch]};
            1: return {30'd0, m_cont[ch], m_ito[ch]};
            2: return 32'(m_period[ch]);
            3: return 32'(m_snap[ch]);
            4: return 32'(m_presc[ch]);
`ifdef MTIMER_PWM_EN
            5: return 32'(m_compare[ch]);
`endif
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_period[c]  = DEF_PERIOD;
                m_snap[c]    = 0;
                m_compare[c] = 0;
                m_elapsed[c] = 0;
                m_presc[c]   = 0;
                m_run[c]     = 1'b0;
                m_to[c]      = 1'b0;
                m_ito[c]     = 1'b0;
                m_cont[c]    = 1'b0;
            end
            exp_rd  = 32'd0;
            exp_pwm = '0;
        end else begin
            m_wr = chipselect && !write_n;
            m_ch = int'(address >> 3);
            m_rg = int'(address[2:0]);
            exp_rd = modelRead(m_ch, m_rg);
            for (int c = 0; c < NUM_CH; c++) begin
                m_cnt   = modelCount(c);
                m_hit   = m_wr && (m_ch == c);
                m_exp   = m_run[c] &&
                          (m_elapsed[c] + 1 == (m_period[c] + 1) * (m_presc[c] + 1));
                m_start = m_hit && (m_rg == 1) && writedata[2];
                m_stop  = m_hit && (m_rg == 1) && writedata[3];
                m_pw    = m_hit && (m_rg == 2);
`ifdef MTIMER_PWM_EN
                exp_pwm[c] = m_run[c] && (m_cnt < m_compare[c]);
`else
                exp_pwm[c] = 1'b0;
`endif
                if (m_run[c]) m_elapsed[c] = m_exp ? 0 : m_elapsed[c] + 1;
                if (m_exp) m_to[c] = 1'b1;
                else if (m_hit && m_rg == 0) m_to[c] = 1'b0;
                if (m_start) m_run[c] = 1'b1;
                else if (m_stop || m_pw || (m_exp && !m_cont[c])) m_run[c] = 1'b0;
                if (m_hit) begin
                    case (m_rg)
                        1: begin m_ito[c] = writedata[0]; m_cont[c] = writedata[1]; end
                        2: begin m_period[c] = longint'(writedata); m_elapsed[c] = 0; end
                        3: m_snap[c] = m_cnt;
                        4: m_presc[c] = longint'(writedata[7:0]);
                        5: m_compare[c] = longint'(writedata);
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    logic [NUM_CH-1:0] exp_vec;

    always @(negedge clk) begin
        if (reset_n && check_en) begin
            for (int c = 0; c < NUM_CH; c++) exp_vec[c] = m_to[c] & m_ito[c];
            checkOutput("cyc_readdata", readdata, exp_rd);
            checkOutput("cyc_irq_vec", 32'(irq_vec), 32'(exp_vec));
            checkOutput("cyc_irq", 32'(irq), 32'(|exp_vec));
            checkOutput("cyc_pwm_out", 32'(pwm_out), 32'(exp_pwm));
        end
    end

    // ------------------------------------------------------------------
    // Bus tasks (entered and left on a falling edge)
    // ------------------------------------------------------------------
    task automatic applyStimulus(input int ch, input int rg, input logic [31:0] data);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = ADDR_W'((ch << 3) | rg);
        writedata  = data;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic readReg(input int ch, input int rg, output logic [31:0] data);
        address = ADDR_W'((ch << 3) | rg);
        @(negedge clk);
        data = readdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts falling edges until irq_vec[idx] is seen high; bounded.
    task automatic waitIrq(input int idx, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!irq_vec[idx] && n < 200);
    endtask

    task automatic countPwm(input int idx, input int window, output int n);
        n = 0;
        repeat (window) begin
            @(negedge clk);
            if (pwm_out[idx]) n++;
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    logic [31:0] rd;
    int          n;

    initial begin
        tests      = 0;
        fails      = 0;
        check_en   = 1'b0;
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        repeat (3) @(negedge clk);
        reset_n  = 1'b1;
        check_en = 1'b1;
        @(negedge clk);

        // Reset state of every register
        checkOutput("reset_irq", 32'(irq), 32'd0);
        checkOutput("reset_pwm", 32'(pwm_out), 32'd0);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            for (int rg = 0; rg < 8; rg++) begin
                readReg(ch, rg, rd);
                checkOutput($sformatf("reset_ch%0d_reg%0d", ch, rg), rd,
                            (rg == 2) ? 32'h249EF : 32'd0);
            end
        end

        // ch1 continuous, PERIOD=9 PRESC=0: IRQ after 10 clocks, then every 10
        applyStimulus(1, 2, 32'd9);
        applyStimulus(1, 1, 32'h7);
        waitIrq(1, n);
        checkOutput("ch1_first_irq_clks", 32'(n), 32'd10);
        applyStimulus(1, 0, 32'd0);
        checkOutput("ch1_status_clear", 32'(irq_vec[1]), 32'd0);
        waitIrq(1, n);
        checkOutput("ch1_next_irq_clks", 32'(n), 32'd9);
        readReg(1, 1, rd);
        checkOutput("ch1_control_read", rd, 32'h3);

        // ch0 one-shot, PERIOD=3 PRESC=4: expiry 20 clocks after START
        applyStimulus(0, 4, 32'd4);
        applyStimulus(0, 2, 32'd3);
        applyStimulus(0, 1, 32'h5);
        waitIrq(0, n);
        checkOutput("ch0_oneshot_clks", 32'(n), 32'd20);
        readReg(0, 0, rd);
        checkOutput("ch0_status_after", rd, 32'h1);
        idle(5);
        applyStimulus(0, 3, 32'd0);
        readReg(0, 3, rd);
        checkOutput("ch0_count_holds", rd, 32'd3);
        readReg(0, 4, rd);
        checkOutput("ch0_presc_read", rd, 32'd4);

        // ch2 PERIOD rewrite mid-count forces a reload and stops the channel
        applyStimulus(2, 2, 32'd1000);
        applyStimulus(2, 1, 32'h6);
        idle(7);
        applyStimulus(2, 2, 32'd100);
        readReg(2, 0, rd);
        checkOutput("ch2_stopped_by_period", rd, 32'h0);
        applyStimulus(2, 3, 32'd0);
        readReg(2, 3, rd);
        checkOutput("ch2_snap_reload", rd, 32'd100);

        // START and STOP together: START wins; STOP alone stops
        applyStimulus(2, 1, 32'hC);
        readReg(2, 0, rd);
        checkOutput("ch2_start_wins", rd, 32'h2);
        applyStimulus(2, 1, 32'h8);
        readReg(2, 0, rd);
        checkOutput("ch2_stop", rd, 32'h0);

        // ch3 STATUS write lands in the expiry cycle: TO must survive
        applyStimulus(3, 2, 32'd4);
        applyStimulus(3, 1, 32'h5);
        idle(4);
        applyStimulus(3, 0, 32'd0);
        checkOutput("ch3_irq_kept", 32'(irq_vec[3]), 32'd1);
        readReg(3, 0, rd);
        checkOutput("ch3_status_set_wins", rd, 32'h1);
        applyStimulus(3, 0, 32'd0);
        readReg(3, 0, rd);
        checkOutput("ch3_status_cleared", rd, 32'h0);

        // ch3 PWM: PERIOD=9, COMPARE=3, continuous
        applyStimulus(3, 5, 32'd3);
        applyStimulus(3, 2, 32'd9);
        applyStimulus(3, 1, 32'h6);
        idle(5);
        countPwm(3, 10, n);
        readReg(3, 5, rd);
`ifdef MTIMER_PWM_EN
        checkOutput("ch3_pwm_high_clks", 32'(n), 32'd3);
        checkOutput("ch3_compare_read", rd, 32'd3);
`else
        checkOutput("ch3_pwm_high_clks", 32'(n), 32'd0);
        checkOutput("ch3_compare_read", rd, 32'd0);
`endif

        // Reserved registers
        readReg(1, 6, rd);
        checkOutput("reserved_reg6", rd, 32'd0);
        readReg(1, 7, rd);
        checkOutput("reserved_reg7", rd, 32'd0);

        idle(3);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
